// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 scanning multiplexer: mode encodings
// and the select-width helper used to size channel indices.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width needed to index n items, never less than one bit.
    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan sequencer for mux_n_1_scan: a dwell counter (0..DWELL-1) and a
// channel counter (0..CHANNELS-1). chan is the channel to sample on the
// current enabled edge; advance is high on the last dwell cycle of it.
// restart forces both counters back to zero on an enabled edge.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1,
    localparam int SEL_W    = sel_width(CHANNELS),
    localparam int DW_W     = sel_width(DWELL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [SEL_W-1:0] chan,
    output logic             advance
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] chan_q, chan_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    assign chan    = chan_q;
    assign advance = (dwell_q == LAST_DW);

    // Next-state: hold when disabled, clear on restart, otherwise step dwell
    // and move to the next channel (with wrap) once the dwell expires.
    always_comb begin
        chan_d  = chan_q;
        dwell_d = dwell_q;
        if (en) begin
            if (restart) begin
                chan_d  = '0;
                dwell_d = '0;
            end else if (advance) begin
                dwell_d = '0;
                chan_d  = (chan_q == LAST_CH) ? '0 : chan_q + SEL_W'(1);
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end
    end

    // Counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q  <= '0;
            dwell_q <= '0;
        end else begin
            chan_q  <= chan_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/mux_n_1_scan.sv
// Parametrised N-to-1 multiplexer with registered output, enable and an
// optional auto-scan mode. Scan logic is built only when MUX_SCAN_EN is
// defined; otherwise mode is ignored and the block is a plain direct mux.
// Channel k of in_bus occupies bits [k*WIDTH +: WIDTH]. All outputs are
// registered and describe the same sample.
module mux_n_1_scan
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 1,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err
);

    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    logic             scan_mode;
    logic [SEL_W-1:0] scan_chan;
    logic [SEL_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_data;
    logic             in_range;

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             sel_err_q, sel_err_d;

`ifdef MUX_SCAN_EN
    logic unused_scan_adv;

    assign scan_mode = (mode == MODE_SCAN);

    // Counters are cleared whenever an enabled edge sees direct mode, so the
    // first scan sample after entering scan mode is always channel 0.
    mux_scan_ctr #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_scan_ctr (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (~scan_mode),
        .chan    (scan_chan),
        .advance (unused_scan_adv)
    );
`else
    logic unused_mode;
    localparam int unused_dwell = DWELL;

    assign unused_mode = mode;
    assign scan_mode   = 1'b0;
    assign scan_chan   = '0;
`endif

    assign pick_idx = scan_mode ? scan_chan : sel;
    assign in_range = ({1'b0, sel} < CH_LIM);

    // Channel lookup for the selected index.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (pick_idx == k[SEL_W-1:0]) begin
                pick_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next sample: scan channel in scan mode, sel in direct mode with an
    // out-of-range sel producing a zero, invalid, flagged sample.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cur_sel_d   = cur_sel_q;
        sel_err_d   = sel_err_q;
        if (en) begin
            cur_sel_d = pick_idx;
            if (scan_mode || in_range) begin
                out_d       = pick_data;
                out_valid_d = 1'b1;
                sel_err_d   = 1'b0;
            end else begin
                out_d       = '0;
                out_valid_d = 1'b0;
                sel_err_d   = 1'b1;
            end
        end
    end

    // Output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cur_sel_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cur_sel_q   <= cur_sel_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Bench for mux_n_1_scan. Two instances share stimulus: dut_a (WIDTH=8,
// CHANNELS=4, DWELL=3) and dut_b (WIDTH=8, CHANNELS=5, DWELL=2). A model
// tracks each instance as "sample position since scan start" and derives
// the channel arithmetically; literal expectations pin the model.
module tb_mux_n_1_scan;

`ifdef MUX_SCAN_EN
    localparam bit SCAN_BUILT = 1'b1;
`else
    localparam bit SCAN_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [39:0] in_bus;

    logic [7:0]  out_a, out_b;
    logic        valid_a, valid_b;
    logic [1:0]  cur_a;
    logic [2:0]  cur_b;
    logic        err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Clock / reset
    always #5 clk = ~clk;

    mux_n_1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus[31:0]),
        .sel       (sel[1:0]),
        .mode      (mode),
        .en        (en),
        .out       (out_a),
        .out_valid (valid_a),
        .cur_sel   (cur_a),
        .sel_err   (err_a)
    );

    mux_n_1_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .sel       (sel),
        .mode      (mode),
        .en        (en),
        .out       (out_b),
        .out_valid (valid_b),
        .cur_sel   (cur_b),
        .sel_err   (err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_out[2], m_valid[2], m_cur[2], m_err[2], m_pos[2];
    bit m_prev_scan[2];

    function automatic int chs(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int dwell_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic int sel_mask(input int i);
        return (i == 0) ? 3 : 7;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_valid[i] = 0; m_cur[i] = 0; m_err[i] = 0;
            m_pos[i] = 0; m_prev_scan[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit scan;
        int ch;
        if (en !== 1'b1) return;
        scan = SCAN_BUILT && (mode === 1'b1);
        for (int i = 0; i < 2; i++) begin
            if (scan) begin
                if (!m_prev_scan[i]) m_pos[i] = 0;
                ch = (m_pos[i] / dwell_of(i)) % chs(i);
                m_out[i] = int'(in_bus[ch*8 +: 8]);
                m_cur[i] = ch; m_valid[i] = 1; m_err[i] = 0;
                m_pos[i]++;
            end else begin
                ch = int'(sel) & sel_mask(i);
                m_cur[i] = ch;
                if (ch < chs(i)) begin
                    m_out[i] = int'(in_bus[ch*8 +: 8]); m_valid[i] = 1; m_err[i] = 0;
                end else begin
                    m_out[i] = 0; m_valid[i] = 0; m_err[i] = 1;
                end
                m_pos[i] = 0;
            end
            m_prev_scan[i] = scan;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Scoreboard compare, every negative edge
    always @(negedge clk) begin
        check("out_a",   out_a,   m_out[0]);
        check("valid_a", valid_a, m_valid[0]);
        check("cur_a",   cur_a,   m_cur[0]);
        check("err_a",   err_a,   m_err[0]);
        check("out_b",   out_b,   m_out[1]);
        check("valid_b", valid_b, m_valid[1]);
        check("cur_b",   cur_b,   m_cur[1]);
        check("err_b",   err_b,   m_err[1]);
    end

    // Driver: apply inputs at negedge, return just after the next posedge
    task automatic cyc(input logic e, input logic m, input logic [2:0] s);
        @(negedge clk);
        en = e; mode = m; sel = s;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] lit_a[4];
    int         exp_seq[13];

    initial begin
        lit_a   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
        in_bus = {8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        @(posedge clk);
        #2;
        check("rst_out",   out_a,   0);
        check("rst_valid", valid_a, 0);
        check("rst_cur",   cur_b,   0);
        check("rst_err",   err_b,   0);
        @(negedge clk);
        rst = 1'b0;

        // Direct mode, sel 0..3
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 1'b0, 3'(s));
            check("dir_out",   out_a,   lit_a[s]);
            check("dir_valid", valid_a, 1);
            check("dir_cur",   cur_a,   s);
        end

        // Out-of-range sel on the 5-channel instance
        cyc(1'b1, 1'b0, 3'd6);
        check("oor_out",   out_b,   0);
        check("oor_valid", valid_b, 0);
        check("oor_err",   err_b,   1);
        check("oor_cur",   cur_b,   6);
        cyc(1'b1, 1'b0, 3'd4);
        check("ch4_err",   err_b,   0);
        check("ch4_out",   out_b,   8'hE5);
        check("ch4_valid", valid_b, 1);

        // Scan sequence (sel=2 ignored when scan is built)
        for (int k = 0; k < 13; k++) begin
            cyc(1'b1, 1'b1, 3'd2);
`ifdef MUX_SCAN_EN
            check("scan_cur", cur_a, exp_seq[k]);
            check("scan_out", out_a, lit_a[exp_seq[k]]);
`else
            check("noscan_cur", cur_a, 2);
            check("noscan_out", out_a, 8'hC3);
`endif
        end

        // Restart scan, run to channel 2 dwell 1, then freeze
        cyc(1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 3'd2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 3'd1);
            check("hold_cur", cur_a, 2);
            check("hold_out", out_a, 8'hC3);
        end
        cyc(1'b1, 1'b1, 3'd2);
        check("resume_cur0", cur_a, 2);
        cyc(1'b1, 1'b1, 3'd2);
        check("resume_cur1", cur_a, 2);
        cyc(1'b1, 1'b1, 3'd2);
`ifdef MUX_SCAN_EN
        check("resume_cur2", cur_a, 3);
`else
        check("resume_cur2", cur_a, 2);
`endif

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_out",   out_a,   0);
        check("arst_cur",   cur_a,   0);
        check("arst_valid", valid_a, 0);
        check("arst_err_b", err_b,   0);
        check("arst_cur_b", cur_b,   0);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 3'd2);
`ifdef MUX_SCAN_EN
        check("post_rst_cur", cur_a, 0);
        check("post_rst_out", out_a, 8'hA1);
`else
        check("post_rst_cur", cur_a, 2);
        check("post_rst_out", out_a, 8'hC3);
`endif

        // Mixed traffic, including a mode change while disabled
        cyc(1'b1, 1'b0, 3'd1);
        cyc(1'b1, 1'b0, 3'd5);
        cyc(1'b0, 1'b1, 3'd3);
        cyc(1'b0, 1'b1, 3'd3);
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b1, 3'd3);
        cyc(1'b1, 1'b0, 3'd7);
        cyc(1'b1, 1'b0, 3'd3);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
